// File: rtl/matrix_multiplier_seq.sv
// rtl/matrix_multiplier_seq.sv - sequential matrix multiplier C = [C +] A*B using one shared MAC
module matrix_multiplier_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS_A     = 2,
    parameter int COLS_A     = 2,
    parameter int COLS_B     = 2,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  accum_en,
    input  logic [ROWS_A*COLS_A*DATA_WIDTH-1:0]   a,
    input  logic [COLS_A*COLS_B*DATA_WIDTH-1:0]   b,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ROWS_A*COLS_B*ACC_WIDTH-1:0]    c,
    output logic                                  busy
);

    localparam int IW = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
    localparam int JW = (COLS_B > 1) ? $clog2(COLS_B) : 1;
    localparam int KW = (COLS_A > 1) ? $clog2(COLS_A) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t state_q, state_d;
    logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0] a_q, a_d;
    logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] b_q, b_d;
    logic [ROWS_A-1:0][COLS_B-1:0][ACC_WIDTH-1:0]  c_q, c_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 accum_q, accum_d;
    logic [IW-1:0]        i_q, i_d;
    logic [JW-1:0]        j_q, j_d;
    logic [KW-1:0]        k_q, k_d;
    logic [ACC_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0] base;

    // Low ACC_WIDTH bits of the product are the same whether operands are
    // treated as signed or unsigned once they are extended to ACC_WIDTH.
    function automatic logic [ACC_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] x);
        if (SIGNED) ext = ACC_WIDTH'($signed(x));
        else        ext = ACC_WIDTH'(x);
    endfunction

    assign prod      = ext(a_q[i_q][k_q]) * ext(b_q[k_q][j_q]);
    assign base      = accum_q ? c_q[i_q][j_q] : '0;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == COMPUTE);
    assign c         = c_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            accum_q <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            accum_q <= accum_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        acc_d   = acc_q;
        accum_d = accum_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    accum_d = accum_en;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                // k innermost, then j, then i; last k closes out element c[i][j]
                if (k_q == KW'(COLS_A-1)) begin
                    c_d[i_q][j_q] = base + acc_q + prod;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == JW'(COLS_B-1)) begin
                        j_d = '0;
                        if (i_q == IW'(ROWS_A-1)) begin
                            i_d     = '0;
                            state_d = DONE;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    acc_d = acc_q + prod;
                    k_d   = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_matrix_multiplier_seq.sv
// tb/tb_matrix_multiplier_seq.sv - scoreboard bench for matrix_multiplier_seq (three parameter sets)
module tb_matrix_multiplier_seq;

    typedef logic [31:0] mat_t [2][2];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   iv, ir, ov, ordy, bsy, ae, man, rr;
    bit           rmode;
    logic [127:0] m_a, m_b;
    logic [287:0] m_c;
    logic [31:0]  s_a, s_b;
    logic [95:0]  s_c;
    logic [31:0]  w_a, w_b, w_c;

    assign ordy = rmode ? rr : man;

    matrix_multiplier_seq u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .accum_en(ae[0]),
        .a(m_a), .b(m_b), .out_valid(ov[0]), .out_ready(ordy[0]), .c(m_c), .busy(bsy[0]));

    matrix_multiplier_seq #(.DATA_WIDTH(8), .ACC_WIDTH(24), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .accum_en(ae[1]),
        .a(s_a), .b(s_b), .out_valid(ov[1]), .out_ready(ordy[1]), .c(s_c), .busy(bsy[1]));

    matrix_multiplier_seq #(.DATA_WIDTH(8), .ACC_WIDTH(8), .SIGNED(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .accum_en(ae[2]),
        .a(w_a), .b(w_b), .out_valid(ov[2]), .out_ready(ordy[2]), .c(w_c), .busy(bsy[2]));

    int n_cmp = 0;
    int n_bad = 0;
    logic [287:0] q[3][$];
    logic [127:0] cprev[3][2][2];

    always @(posedge clk) begin
        #1 rr = 3'($urandom);
    end

    task automatic chk(input string nm, input logic [287:0] got, input logic [287:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] mask(input int n);
        return (128'd1 << n) - 128'd1;
    endfunction

    function automatic logic [127:0] ext(input logic [31:0] x, input int dw, input bit sgn);
        logic [127:0] v;
        v = 128'(x) & mask(dw);
        if (sgn && v[dw-1]) v = v | ~mask(dw);
        return v;
    endfunction

    // Reference: plain matrix product (plus held C when accumulating), reduced mod 2^aw.
    task automatic model(input int id, input mat_t ea, input mat_t eb, input bit acc,
                         output logic [287:0] exp);
        int dw, aw;
        bit sgn;
        logic [127:0] s;
        case (id)
            0:       begin dw = 32; aw = 72; sgn = 1'b0; end
            1:       begin dw = 8;  aw = 24; sgn = 1'b1; end
            default: begin dw = 8;  aw = 8;  sgn = 1'b0; end
        endcase
        exp = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = acc ? cprev[id][i][j] : 128'd0;
                for (int k = 0; k < 2; k++) s = s + ext(ea[i][k], dw, sgn) * ext(eb[k][j], dw, sgn);
                s = s & mask(aw);
                cprev[id][i][j] = s;
                for (int bt = 0; bt < aw; bt++) exp[(i*2+j)*aw+bt] = s[bt];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input mat_t ea, input mat_t eb);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                case (id)
                    0:       begin m_a[(i*2+k)*32 +: 32] = ea[i][k]; m_b[(i*2+k)*32 +: 32] = eb[i][k]; end
                    1:       begin s_a[(i*2+k)*8 +: 8] = ea[i][k][7:0]; s_b[(i*2+k)*8 +: 8] = eb[i][k][7:0]; end
                    default: begin w_a[(i*2+k)*8 +: 8] = ea[i][k][7:0]; w_b[(i*2+k)*8 +: 8] = eb[i][k][7:0]; end
                endcase
            end
        end
    endtask

    task automatic scramble();
        m_a = {$urandom, $urandom, $urandom, $urandom};
        m_b = {$urandom, $urandom, $urandom, $urandom};
        s_a = $urandom; s_b = $urandom; w_a = $urandom; w_b = $urandom;
    endtask

    task automatic send(input int id, input mat_t ea, input mat_t eb, input bit acc);
        logic [287:0] e;
        int t;
        t = 0;
        drive(id, ea, eb);
        ae[id] = acc;
        iv[id] = 1'b1;
        while (!ir[id] && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: instance %0d in_ready stayed 0", id);
            iv[id] = 1'b0;
            return;
        end
        tick();
        iv[id] = 1'b0;
        ae[id] = $urandom_range(0, 1);
        scramble();
        model(id, ea, eb, acc, e);
        q[id].push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results never presented", q[0].size() + q[1].size() + q[2].size());
        end
    endtask

    always @(negedge clk) begin
        logic [287:0] got;
        logic [287:0] exp;
        if (rst_n) begin
            for (int n = 0; n < 3; n++) begin
                if (ov[n] && ordy[n]) begin
                    case (n)
                        0:       got = m_c;
                        1:       got = 288'(s_c);
                        default: got = 288'(w_c);
                    endcase
                    if (q[n].size() == 0) begin
                        chk($sformatf("unexpected_output_%0d", n), got, 288'hx);
                    end else begin
                        exp = q[n].pop_front();
                        chk($sformatf("result_%0d", n), got, exp);
                    end
                end
            end
        end
    end

    initial begin
        mat_t a1, b1, ra, rb;
        int cnt, busyc;
        logic [287:0] hold;
        a1 = '{'{32'd1, 32'd2}, '{32'd3, 32'd4}};
        b1 = '{'{32'd5, 32'd6}, '{32'd7, 32'd8}};
        rst_n = 1'b0; iv = '0; ae = '0; man = '0; rmode = 1'b0;
        m_a = '0; m_b = '0; s_a = '0; s_b = '0; w_a = '0; w_b = '0;
        for (int n = 0; n < 3; n++) for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) cprev[n][i][j] = '0;
        repeat (3) tick();
        chk("reset_in_ready", ir, 3'b111);
        chk("reset_out_valid", ov, 3'b000);
        chk("reset_busy", bsy, 3'b000);
        chk("reset_c", m_c, '0);
        rst_n = 1'b1;
        tick();

        // basic product, latency and busy window
        send(0, a1, b1, 1'b0);
        chk("busy_at_accept", bsy[0], 1'b1);
        cnt = 0; busyc = 0;
        while (!ov[0] && cnt < 50) begin
            if (bsy[0]) busyc++;
            tick();
            cnt++;
        end
        chk("latency", cnt, 8);
        chk("busy_cycles", busyc, 8);
        chk("busy_in_done", bsy[0], 1'b0);

        // backpressure: output held, new operands refused
        hold = m_c;
        for (int n = 0; n < 5; n++) begin
            iv[0] = 1'b1;
            m_a = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("bp_out_valid", ov[0], 1'b1);
            chk("bp_c_stable", m_c, hold);
            chk("bp_in_ready", ir[0], 1'b0);
        end
        iv[0] = 1'b0;
        man = 3'b111;
        tick();
        chk("hs_in_ready", ir[0], 1'b1);
        chk("hs_out_valid", ov[0], 1'b0);

        send(0, a1, b1, 1'b1);
        send(1, '{'{32'hFF, 32'h0}, '{32'h0, 32'hFF}}, '{'{32'd2, 32'd3}, '{32'd4, 32'd5}}, 1'b0);
        send(2, '{'{32'd255, 32'd255}, '{32'd0, 32'd0}}, '{'{32'd255, 32'd0}, '{32'd255, 32'd0}}, 1'b0);
        drain();

        // abort mid-compute
        man[0] = 1'b0;
        send(0, a1, b1, 1'b1);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", ov, 3'b000);
        chk("abort_busy", bsy, 3'b000);
        chk("abort_c", m_c, '0);
        chk("abort_in_ready", ir, 3'b111);
        for (int n = 0; n < 3; n++) begin
            q[n].delete();
            for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) cprev[n][i][j] = '0;
        end
        tick();
        rst_n = 1'b1;
        man = 3'b111;
        tick();
        send(0, a1, b1, 1'b0);
        drain();

        rmode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 2; k++) begin
                    ra[i][k] = $urandom;
                    rb[i][k] = $urandom;
                end
            end
            send($urandom_range(0, 2), ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();
        rmode = 1'b0;
        chk("queues_empty", q[0].size() + q[1].size() + q[2].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
